// File: rtl/sdram_cmd_arbiter_pkg.sv
// Shared SDRAM definitions: command encodings, bus width defaults and the arbiter's
// one-hot state encoding.
package sdram_cmd_arbiter_pkg;

  localparam int unsigned SDRAM_ADDR_WIDTH_DEF = 12;
  localparam int unsigned SDRAM_BANK_WIDTH_DEF = 2;

  // {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] COMMAND_MRS   = 4'b0000;
  localparam logic [3:0] COMMAND_REF   = 4'b0001;
  localparam logic [3:0] COMMAND_PRE   = 4'b0010;
  localparam logic [3:0] COMMAND_ACT   = 4'b0011;
  localparam logic [3:0] COMMAND_WRITE = 4'b0100;
  localparam logic [3:0] COMMAND_READ  = 4'b0101;
  localparam logic [3:0] COMMAND_NOP   = 4'b0111;

  typedef enum logic [5:0] {
    StIdle = 6'b000001,
    StInit = 6'b000010,
    StArb  = 6'b000100,
    StArf  = 6'b001000,
    StRd   = 6'b010000,
    StWr   = 6'b100000
  } arb_state_e;

  function automatic logic is_busy(arb_state_e s);
    return (s == StArf) || (s == StWr) || (s == StRd);
  endfunction

endpackage

// File: rtl/sdram_arb_wdt.sv
// Watchdog for the arbiter's ARF/WR/RD states: flags a timeout on the last allowed
// cycle when the granted engine has not reported done.
module sdram_arb_wdt #(
  parameter int unsigned WDT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_busy,
  input  logic i_done,
  output logic o_timeout
);

  localparam int unsigned CW = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;

  logic [CW-1:0] r_cnt;

  // Counter is zero on the first busy cycle because ARB always precedes a grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_busy && !o_timeout) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_timeout = i_busy && !i_done && (r_cnt == CW'(WDT_CYCLES - 1));

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// Arbiter/sequencer for the shared SDRAM command bus (ARF > WR > RD, write-starvation
// guard for reads). Optional watchdog enabled by defining SDRAM_ARB_WDT_EN.
module sdram_cmd_arbiter
  import sdram_cmd_arbiter_pkg::*;
#(
  parameter int unsigned SDRAM_ADDR_WIDTH = SDRAM_ADDR_WIDTH_DEF,
  parameter int unsigned SDRAM_BANK_WIDTH = SDRAM_BANK_WIDTH_DEF,
  parameter int unsigned WR_STARVE_MAX    = 4,
  parameter int unsigned WDT_CYCLES       = 1024
) (
  input  logic                        Sys_clk,
  input  logic                        Rst_n,
  input  logic                        INIT_DONE,
  input  logic [3:0]                  COMMAND_INIT,
  input  logic [SDRAM_ADDR_WIDTH-1:0] INIT_A_ADDR,
  input  logic [SDRAM_BANK_WIDTH-1:0] INIT_BANK_ADDR,
  input  logic                        ARF_req,
  input  logic                        REF_DONE,
  input  logic [3:0]                  COMMAND_REF,
  input  logic [SDRAM_ADDR_WIDTH-1:0] ARF_A_ADDR,
  input  logic [SDRAM_BANK_WIDTH-1:0] ARF_BANK_ADDR,
  input  logic                        WR_req,
  input  logic                        WR_data_done,
  input  logic [3:0]                  COMMAND_WR,
  input  logic [SDRAM_ADDR_WIDTH-1:0] WR_A_ADDR,
  input  logic [SDRAM_BANK_WIDTH-1:0] WR_BANK_ADDR,
  input  logic                        RD_req,
  input  logic                        RD_DATA_DONE,
  input  logic [3:0]                  COMMAND_RD,
  input  logic [SDRAM_ADDR_WIDTH-1:0] RD_A_ADDR,
  input  logic [SDRAM_BANK_WIDTH-1:0] RD_BANK_ADDR,
  output logic                        ARF_access,
  output logic                        WR_access,
  output logic                        RD_access,
  output logic                        Break_req,
  output logic [3:0]                  SDRAM_CMD,
  output logic [SDRAM_ADDR_WIDTH-1:0] SDRAM_A_ADDR,
  output logic [SDRAM_BANK_WIDTH-1:0] SDRAM_BANK_ADDR,
  output logic                        DQ_OE,
  output logic [5:0]                  Arb_state,
  output logic                        Wdt_err
);

  localparam int unsigned SW = (WR_STARVE_MAX > 0) ? $clog2(WR_STARVE_MAX + 1) : 1;

  arb_state_e    r_state;
  logic [SW-1:0] r_starve;
  logic          r_init_seen;

  logic w_arb, w_starved, w_pick_arf, w_pick_wr, w_pick_rd, w_done, w_timeout;

  assign w_arb      = (r_state == StArb);
  assign w_starved  = RD_req && (r_starve >= SW'(WR_STARVE_MAX));
  assign w_pick_arf = w_arb && ARF_req;
  assign w_pick_wr  = w_arb && !ARF_req && WR_req && !w_starved;
  assign w_pick_rd  = w_arb && !ARF_req && !w_pick_wr && RD_req;

  // Only the granted engine's done is honoured.
  always_comb begin
    w_done = 1'b0;
    case (r_state)
      StArf:   w_done = REF_DONE;
      StWr:    w_done = WR_data_done;
      StRd:    w_done = RD_DATA_DONE;
      default: w_done = 1'b0;
    endcase
  end

`ifdef SDRAM_ARB_WDT_EN
  sdram_arb_wdt #(
    .WDT_CYCLES(WDT_CYCLES)
  ) u_wdt (
    .i_clk    (Sys_clk),
    .i_rst_n  (Rst_n),
    .i_busy   (is_busy(r_state)),
    .i_done   (w_done),
    .o_timeout(w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= StIdle;
      r_starve    <= '0;
      r_init_seen <= 1'b0;
    end else begin
      if (INIT_DONE) r_init_seen <= 1'b1;
      unique case (r_state)
        StIdle: r_state <= StInit;
        StInit: if (INIT_DONE || r_init_seen) r_state <= StArb;
        StArb: begin
          if (w_pick_arf)     r_state <= StArf;
          else if (w_pick_wr) r_state <= StWr;
          else if (w_pick_rd) r_state <= StRd;
          if (w_pick_rd || !RD_req) begin
            r_starve <= '0;
          end else if (w_pick_wr && (r_starve < SW'(WR_STARVE_MAX))) begin
            r_starve <= r_starve + 1'b1;
          end
        end
        StArf, StWr, StRd: if (w_done || w_timeout) r_state <= StArb;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    SDRAM_CMD       = COMMAND_NOP;
    SDRAM_A_ADDR    = '0;
    SDRAM_BANK_ADDR = '0;
    case (r_state)
      StInit: begin
        SDRAM_CMD       = COMMAND_INIT;
        SDRAM_A_ADDR    = INIT_A_ADDR;
        SDRAM_BANK_ADDR = INIT_BANK_ADDR;
      end
      StArf: begin
        SDRAM_CMD       = COMMAND_REF;
        SDRAM_A_ADDR    = ARF_A_ADDR;
        SDRAM_BANK_ADDR = ARF_BANK_ADDR;
      end
      StWr: begin
        SDRAM_CMD       = COMMAND_WR;
        SDRAM_A_ADDR    = WR_A_ADDR;
        SDRAM_BANK_ADDR = WR_BANK_ADDR;
      end
      StRd: begin
        SDRAM_CMD       = COMMAND_RD;
        SDRAM_A_ADDR    = RD_A_ADDR;
        SDRAM_BANK_ADDR = RD_BANK_ADDR;
      end
      default: ;
    endcase
  end

  assign ARF_access = w_pick_arf;
  assign WR_access  = w_pick_wr;
  assign RD_access  = w_pick_rd;
  assign Break_req  = ((r_state == StWr) || (r_state == StRd)) && ARF_req;
  assign DQ_OE      = (r_state == StWr);
  assign Arb_state  = r_state;
  assign Wdt_err    = w_timeout;

endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
Standalone arbiter and sequencer for the shared SDRAM command/address bus. Grants the bus to the init, auto-refresh, write and read engines. Fixed priority ARF > WR > RD, with a write-starvation guard for reads. Multiplexes the granted engine's command, A and BA outputs onto the pins, drives the DQ output-enable, and asks an active burst to break when a refresh is pending.

Parameters:
SDRAM_ADDR_WIDTH, 12, width of A address bus
SDRAM_BANK_WIDTH, 2, width of bank address
WR_STARVE_MAX, 4, consecutive WR grants with RD pending before RD wins over WR
WDT_CYCLES, 1024, max cycles in ARF/WR/RD without done (watchdog build only)

Ports:
Sys_clk  in  1  system/SDRAM clock
Rst_n  in  1  asynchronous active-low reset
INIT_DONE  in  1  init engine finished; treated as sticky once seen
COMMAND_INIT/INIT_A_ADDR/INIT_BANK_ADDR  in  4/AW/BW  init engine bus
ARF_req, REF_DONE  in  1,1  refresh request, refresh finished
COMMAND_REF/ARF_A_ADDR/ARF_BANK_ADDR  in  4/AW/BW  refresh engine bus
WR_req, WR_data_done  in  1,1  write request, write burst finished
COMMAND_WR/WR_A_ADDR/WR_BANK_ADDR  in  4/AW/BW  write engine bus
RD_req, RD_DATA_DONE  in  1,1  read request, read burst finished
COMMAND_RD/RD_A_ADDR/RD_BANK_ADDR  in  4/AW/BW  read engine bus
ARF_access, WR_access, RD_access  out  1 each  grant strobes
Break_req  out  1  ask active WR/RD engine to close its burst
SDRAM_CMD  out  4  {CS_N,RAS_N,CAS_N,WE_N}
SDRAM_A_ADDR  out  AW  A pins
SDRAM_BANK_ADDR  out  BW  BA pins
DQ_OE  out  1  write data drive enable
Arb_state  out  6  one-hot state, debug
Wdt_err  out  1  watchdog timeout pulse (0 when feature off)

Behaviour:
- States (one-hot): IDLE=000001, INIT=000010, ARB=000100, ARF=001000, RD=010000, WR=100000.
- Reset: state=IDLE, starve count=0, init-seen flag=0. All outputs follow from state: SDRAM_CMD=NOP 4'b0111, A=0, BA=0, DQ_OE=0, strobes=0, Break_req=0, Wdt_err=0.
- IDLE->INIT unconditionally after 1 cycle. INIT->ARB when INIT_DONE=1 or the flag is set. A later INIT_DONE drop is ignored.
- ARB decision, one cycle:
  - ARF_req -> ARF.
  - else WR_req and not (RD_req and cnt>=WR_STARVE_MAX) -> WR.
  - else RD_req -> RD.
  - else stay in ARB.
- Access strobes are combinational: high only in ARB, in the same cycle as the matching transition. At most one is high per cycle.
- Starve count:
  - +1 on each WR grant made while RD_req=1, saturating at WR_STARVE_MAX.
  - cleared on each RD grant.
  - cleared in ARB when RD_req=0.
- ARF->ARB on REF_DONE. WR->ARB on WR_data_done. RD->ARB on RD_DATA_DONE.
- ARB is held at least 1 cycle between grants, so back-to-back grants are 1 cycle apart.
- Break_req = (state WR or RD) and ARF_req. Combinational, no latency. The engine terminates its burst and pulses its done signal. The arbiter only leaves WR/RD on done.
- Done and ARF_req in the same cycle: go to ARB, then ARF on the next cycle.
- Done pulses from a non-granted engine are ignored.
- Output mux is combinational from state:
  - INIT/ARF/WR/RD select the matching engine's command, A and BA.
  - IDLE/ARB output NOP, A=0, BA=0.
- DQ_OE = (state==WR).
- Asynchronous reset mid-burst returns immediately to IDLE with NOP on the bus. Engines are reset by the same Rst_n.

Optional Feature:
Macro SDRAM_ARB_WDT_EN.
- Defined: a counter clears on entry to ARF/WR/RD and counts each cycle in those states. At WDT_CYCLES-1 without the relevant done, the state is forced to ARB and Wdt_err pulses 1 cycle. The starve count is unchanged.
- Undefined: no counter, Wdt_err tied 0, states wait for done indefinitely.

Decomposition:
- Shared header sdram_param.h (already used by the engines) holds command encodings (COMMAND_NOP etc.).
- Add to the same header: the arbiter state one-hot localparams, and the AW/BW defaults.
- One natural sub-module: sdram_arb_wdt, holding the watchdog counter and timeout pulse. It is instantiated only under SDRAM_ARB_WDT_EN.

Test Plan:
- Reset release, INIT_DONE high at cycle 20 -> INIT cmd passthrough until then; ARB at cycle 21; bus NOP in ARB.
- ARF_req, WR_req and RD_req all high in ARB -> ARF_access pulse; ARF state; after REF_DONE, ARB 1 cycle, then WR_access; after WR_data_done, RD_access.
- WR_req and RD_req held high with done 8 cycles after each grant -> grant order WR,WR,WR,WR,RD,WR... for WR_STARVE_MAX=4.
- ARF_req asserted in WR at burst cycle 3 -> Break_req=1 the same cycle; engine done at cycle 5 -> ARB, then ARF; DQ_OE falls with WR exit.
- Rst_n low while in RD -> next evaluation shows Arb_state=000001, SDRAM_CMD=4'b0111, all strobes 0.
- With SDRAM_ARB_WDT_EN and WDT_CYCLES=16, WR granted with no done -> ARB after 16 cycles in WR, Wdt_err one pulse. Without the macro, the bench sees it stay in WR and Wdt_err=0.
